// File: rtl/veerwolf_board_pkg.sv
// Shared board constants for the veerwolf board I/O conditioner.
// Per-board pin counts and debounce timings live here so each toplevel only picks a set.
package veerwolf_board_pkg;

    localparam int unsigned DEBOUNCE_10MS_25MHZ = 250000;
    localparam int unsigned SIM_DEBOUNCE        = 4;

    // Nexys A7 and Basys3 both expose 16 switches plus 5 buttons and 16 LEDs.
    localparam int unsigned NEXYS_A7_NUM_IN  = 21;
    localparam int unsigned NEXYS_A7_NUM_LED = 16;
    localparam int unsigned BASYS3_NUM_IN    = 21;
    localparam int unsigned BASYS3_NUM_LED   = 16;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    localparam int unsigned DEFAULT_PWM_BITS    = 4;

    // Debounce counter width; a bypassed debouncer keeps a minimal 1-bit width.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/veerwolf_debounce.sv
// Single-bit input conditioner: multi-flop synchroniser followed by a hold-time debouncer.
// stable_o only follows the synchronised level once it has held for DEBOUNCE_CYCLES cycles.
module veerwolf_debounce
    import veerwolf_board_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic stable_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   stable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_ff @(posedge clk) begin
            if (rst) begin
                stable_q <= 1'b0;
            end else begin
                stable_q <= sync;
            end
        end
    end else begin : g_count
        localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
        localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

        logic [CntW-1:0] cnt_q, cnt_d;
        logic            stable_d;

        // Any cycle where sync agrees with stable restarts the hold window.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (sync != stable_q) begin
                if (cnt_q == CntLast) begin
                    stable_d = sync;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/veerwolf_board_io.sv
// Board-level I/O conditioner between FPGA pins and the veerwolf GPIO bus: debounced inputs
// with edge pulses, sticky events and a maskable IRQ, plus PWM-dimmed registered LED outputs.
module veerwolf_board_io
    import veerwolf_board_pkg::*;
#(
    parameter int unsigned NUM_IN          = NEXYS_A7_NUM_IN,
    parameter int unsigned NUM_LED         = NEXYS_A7_NUM_LED,
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
    parameter int unsigned PWM_BITS        = DEFAULT_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IN-1:0]   i_in,
    output logic [NUM_IN-1:0]   o_in_db,
    output logic [NUM_IN-1:0]   o_rise,
    output logic [NUM_IN-1:0]   o_fall,
    output logic [NUM_IN-1:0]   o_evt_pend,
    input  logic [NUM_IN-1:0]   i_evt_clr,
    input  logic [NUM_IN-1:0]   i_evt_en,
    input  logic [NUM_IN-1:0]   i_evt_rise_sel,
    output logic                o_irq,
    input  logic [NUM_LED-1:0]  i_led,
    input  logic [PWM_BITS-1:0] i_led_duty,
    output logic [NUM_LED-1:0]  o_led
);

    logic [NUM_IN-1:0]   stable;
    logic [NUM_IN-1:0]   stable_dly_q;
    logic [NUM_IN-1:0]   rise_q, fall_q;
    logic [NUM_IN-1:0]   pend_q, pend_d;
    logic [NUM_IN-1:0]   evt_set;
    logic                irq_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_on;
    logic [NUM_LED-1:0]  led_r_q, led_q;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        veerwolf_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst      (rst),
            .in_i     (i_in[k]),
            .stable_o (stable[k])
        );
    end

    // A set landing in the same cycle as its clear wins, so no event is lost.
    always_comb begin
        evt_set = (i_evt_rise_sel & rise_q) | (~i_evt_rise_sel & fall_q);
        pend_d  = (pend_q & ~i_evt_clr) | evt_set;
    end

    // Full-scale duty is forced fully on rather than 15/16.
    assign pwm_on = (pwm_cnt_q < i_led_duty) | (&i_led_duty);

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_dly_q <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            pend_q       <= '0;
            irq_q        <= 1'b0;
            pwm_cnt_q    <= '0;
            led_r_q      <= '0;
            led_q        <= '0;
        end else begin
            stable_dly_q <= stable;
            rise_q       <= stable & ~stable_dly_q;
            fall_q       <= ~stable & stable_dly_q;
            pend_q       <= pend_d;
            irq_q        <= |(pend_q & i_evt_en);
            pwm_cnt_q    <= pwm_cnt_q + PWM_BITS'(1);
            led_r_q      <= i_led & {NUM_LED{pwm_on}};
            led_q        <= led_r_q;
        end
    end

    assign o_in_db    = stable;
    assign o_rise     = rise_q;
    assign o_fall     = fall_q;
    assign o_evt_pend = pend_q;
    assign o_irq      = irq_q;
    assign o_led      = led_q;

endmodule

// File: tb/tb_veerwolf_board_io.sv
// Self-checking bench for veerwolf_board_io: directed scenarios plus a randomized run
// against a cycle-level behavioural model; a second instance covers the debounce bypass build.
module tb_veerwolf_board_io;

    localparam int NI = 4;
    localparam int NL = 4;
    localparam int PB = 4;
    localparam int DB = 4;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_v = 1'b1;
    logic [NI-1:0] in_v = '0;
    logic [NI-1:0] clr_v = '0;
    logic [NI-1:0] en_v = '0;
    logic [NI-1:0] sel_v = '0;
    logic [NL-1:0] led_v = '0;
    logic [PB-1:0] duty_v = '0;

    logic [NI-1:0] o_in_db, o_rise, o_fall, o_evt_pend;
    logic          o_irq;
    logic [NL-1:0] o_led;
    logic [NI-1:0] bp_in_db, bp_rise, bp_fall, bp_pend;
    logic          bp_irq;
    logic [NL-1:0] bp_led;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    veerwolf_board_io #(
        .NUM_IN(NI), .NUM_LED(NL), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB)
    ) dut (
        .clk(clk), .rst(rst_v), .i_in(in_v), .o_in_db(o_in_db), .o_rise(o_rise),
        .o_fall(o_fall), .o_evt_pend(o_evt_pend), .i_evt_clr(clr_v), .i_evt_en(en_v),
        .i_evt_rise_sel(sel_v), .o_irq(o_irq), .i_led(led_v), .i_led_duty(duty_v),
        .o_led(o_led)
    );

    veerwolf_board_io #(
        .NUM_IN(NI), .NUM_LED(NL), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(0), .PWM_BITS(PB)
    ) dut_bp (
        .clk(clk), .rst(rst_v), .i_in(in_v), .o_in_db(bp_in_db), .o_rise(bp_rise),
        .o_fall(bp_fall), .o_evt_pend(bp_pend), .i_evt_clr(clr_v), .i_evt_en(en_v),
        .i_evt_rise_sel(sel_v), .o_irq(bp_irq), .i_led(led_v), .i_led_duty(duty_v),
        .o_led(bp_led)
    );

    // Behavioural model: pins reach the debouncer SS cycles late; a level is accepted once
    // the last DB synchronised samples all disagree with the accepted level.
    logic [NI-1:0] pin_hist[$];
    logic [NI-1:0] sync_hist[$];
    logic [NI-1:0] m_db, m_db_prev, m_rise, m_fall, m_pend;
    logic [NI-1:0] m_bp, m_bp_prev, m_bp_rise, m_bp_fall, m_bp_pend;
    logic          m_irq, m_bp_irq;
    logic [NL-1:0] m_led, m_led_mid;
    int            m_tick;

    task automatic step();
        logic [NI-1:0] p, c, e, s, sync, n_db;
        logic [NL-1:0] l;
        logic [PB-1:0] d;
        logic          r, on, flip;
        p = in_v; c = clr_v; e = en_v; s = sel_v; l = led_v; d = duty_v; r = rst_v;
        @(posedge clk);
        if (r) begin
            pin_hist.delete();
            sync_hist.delete();
            repeat (SS) pin_hist.push_back('0);
            repeat (DB) sync_hist.push_back('0);
            m_db = '0; m_db_prev = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
            m_bp = '0; m_bp_prev = '0; m_bp_rise = '0; m_bp_fall = '0; m_bp_pend = '0;
            m_bp_irq = 1'b0; m_led = '0; m_led_mid = '0; m_tick = 0;
        end else begin
            pin_hist.push_back(p);
            sync = pin_hist[0];
            void'(pin_hist.pop_front());
            sync_hist.push_back(sync);
            void'(sync_hist.pop_front());
            n_db = m_db;
            for (int k = 0; k < NI; k++) begin
                flip = 1'b1;
                for (int j = 0; j < DB; j++) if (sync_hist[j][k] == m_db[k]) flip = 1'b0;
                if (flip) n_db[k] = ~m_db[k];
            end
            m_irq     = |(m_pend & e);
            m_pend    = (m_pend & ~c) | ((s & m_rise) | (~s & m_fall));
            m_rise    = m_db & ~m_db_prev;
            m_fall    = ~m_db & m_db_prev;
            m_db_prev = m_db;
            m_db      = n_db;
            m_bp_irq  = |(m_bp_pend & e);
            m_bp_pend = (m_bp_pend & ~c) | ((s & m_bp_rise) | (~s & m_bp_fall));
            m_bp_rise = m_bp & ~m_bp_prev;
            m_bp_fall = ~m_bp & m_bp_prev;
            m_bp_prev = m_bp;
            m_bp      = sync;
            on        = (d == {PB{1'b1}}) || ((m_tick % (1 << PB)) < int'(d));
            m_tick++;
            m_led     = m_led_mid;
            m_led_mid = on ? l : '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        step();
        step();
        rst_v = 1'b0;
    endtask

    task automatic test_reset();
        in_v = '0; clr_v = '0; en_v = '0; sel_v = '0; led_v = '0; duty_v = '0;
        rst_v = 1'b1;
        step();
        step();
        n_checks++;
        if ({o_in_db, o_rise, o_fall, o_evt_pend, o_irq, o_led} !== '0)
            $display("FAIL reset_main: got %h want 0",
                     {o_in_db, o_rise, o_fall, o_evt_pend, o_irq, o_led});
        else n_pass++;
        n_checks++;
        if ({bp_in_db, bp_rise, bp_fall, bp_pend, bp_irq, bp_led} !== '0)
            $display("FAIL reset_bypass: got %h want 0",
                     {bp_in_db, bp_rise, bp_fall, bp_pend, bp_irq, bp_led});
        else n_pass++;
        rst_v = 1'b0;
        step();
        n_checks++;
        if ({o_in_db, o_evt_pend, o_irq, o_led} !== '0)
            $display("FAIL reset_release: got %h want 0", {o_in_db, o_evt_pend, o_irq, o_led});
        else n_pass++;
    endtask

    task automatic test_clean_edge();
        in_v[0] = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            step();
            n_checks++;
            if (o_in_db[0] !== (n >= 6))
                $display("FAIL clean_in_db cycle %0d: got %b want %b", n, o_in_db[0], n >= 6);
            else n_pass++;
            n_checks++;
            if (o_rise[0] !== (n == 7))
                $display("FAIL clean_rise cycle %0d: got %b want %b", n, o_rise[0], n == 7);
            else n_pass++;
            n_checks++;
            if (o_fall[0] !== 1'b0)
                $display("FAIL clean_fall cycle %0d: got %b want 0", n, o_fall[0]);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        sel_v = '1;
        in_v[1] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 3) in_v[1] = 1'b0;
            n_checks++;
            if ({o_in_db[1], o_rise[1], o_evt_pend[1]} !== 3'b000)
                $display("FAIL glitch_reject cycle %0d: got db/rise/pend %b want 000", n,
                         {o_in_db[1], o_rise[1], o_evt_pend[1]});
            else n_pass++;
        end
        in_v[1] = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            step();
            if (n == 4) in_v[1] = 1'b0;
            n_checks++;
            if (o_in_db[1] !== (n >= 6 && n <= 9))
                $display("FAIL glitch_accept cycle %0d: got %b want %b", n, o_in_db[1],
                         n >= 6 && n <= 9);
            else n_pass++;
            n_checks++;
            if (o_evt_pend[1] !== (n >= 8))
                $display("FAIL glitch_pend cycle %0d: got %b want %b", n, o_evt_pend[1], n >= 8);
            else n_pass++;
        end
    endtask

    task automatic test_events();
        in_v = '0; clr_v = '0; en_v = '0; sel_v = '1;
        do_reset();
        en_v = 4'h1;
        in_v[2] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            n_checks++;
            if (o_irq !== 1'b0) $display("FAIL evt_irq_masked cycle %0d: got %b want 0", n, o_irq);
            else n_pass++;
        end
        n_checks++;
        if (o_evt_pend !== 4'h4) $display("FAIL evt_pend_set: got %h want 4", o_evt_pend);
        else n_pass++;
        en_v = 4'h4;
        n_checks++;
        if (o_irq !== 1'b0) $display("FAIL evt_irq_lag: got %b want 0", o_irq);
        else n_pass++;
        step();
        n_checks++;
        if (o_irq !== 1'b1) $display("FAIL evt_irq_enable: got %b want 1", o_irq);
        else n_pass++;
        in_v[2] = 1'b0;
        repeat (12) step();
        n_checks++;
        if (o_evt_pend !== 4'h4) $display("FAIL evt_fall_ignored: got %h want 4", o_evt_pend);
        else n_pass++;
        in_v[2] = 1'b1;
        repeat (7) step();
        n_checks++;
        if (o_rise[2] !== 1'b1) $display("FAIL evt_rise_again: got %b want 1", o_rise[2]);
        else n_pass++;
        clr_v = 4'h4;
        step();
        n_checks++;
        if (o_evt_pend !== 4'h4) $display("FAIL evt_set_wins: got %h want 4", o_evt_pend);
        else n_pass++;
        step();
        n_checks++;
        if ({o_evt_pend, o_irq} !== {4'h0, 1'b1})
            $display("FAIL evt_clear: got pend %h irq %b want pend 0 irq 1", o_evt_pend, o_irq);
        else n_pass++;
        clr_v = '0;
        step();
        n_checks++;
        if (o_irq !== 1'b0) $display("FAIL evt_irq_drop: got %b want 0", o_irq);
        else n_pass++;
    endtask

    task automatic test_pwm();
        int on_cnt, bad_cnt;
        led_v = 4'hF; duty_v = 4'd4;
        do_reset();
        repeat (2) step();
        for (int w = 0; w < 2; w++) begin
            on_cnt = 0; bad_cnt = 0;
            for (int n = 0; n < 16; n++) begin
                step();
                if (o_led == 4'hF) on_cnt++;
                else if (o_led != 4'h0) bad_cnt++;
            end
            n_checks++;
            if (on_cnt != 4 || bad_cnt != 0)
                $display("FAIL pwm_duty4 window %0d: got %0d on, %0d bad want 4 on, 0 bad",
                         w, on_cnt, bad_cnt);
            else n_pass++;
        end
        duty_v = 4'd0;
        repeat (2) step();
        bad_cnt = 0;
        for (int n = 0; n < 16; n++) begin
            step();
            if (o_led != 4'h0) bad_cnt++;
        end
        n_checks++;
        if (bad_cnt != 0) $display("FAIL pwm_duty0: got %0d lit cycles want 0", bad_cnt);
        else n_pass++;
        duty_v = 4'd15;
        repeat (2) step();
        bad_cnt = 0;
        for (int n = 0; n < 16; n++) begin
            step();
            if (o_led != 4'hF) bad_cnt++;
        end
        n_checks++;
        if (bad_cnt != 0) $display("FAIL pwm_duty15: got %0d dark cycles want 0", bad_cnt);
        else n_pass++;
        led_v = 4'h5;
        step();
        n_checks++;
        if (o_led !== 4'hF) $display("FAIL pwm_led_lat1: got %h want f", o_led);
        else n_pass++;
        step();
        n_checks++;
        if (o_led !== 4'h5) $display("FAIL pwm_led_lat2: got %h want 5", o_led);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        in_v = '0; clr_v = '0; en_v = '0; sel_v = '1;
        do_reset();
        in_v = 4'hA;
        repeat (9) step();
        n_checks++;
        if (o_evt_pend !== 4'hA) $display("FAIL rstmid_pre_pend: got %h want a", o_evt_pend);
        else n_pass++;
        in_v = 4'hB;
        repeat (5) step();
        rst_v = 1'b1;
        step();
        n_checks++;
        if ({o_in_db, o_rise, o_fall, o_evt_pend, o_irq, o_led} !== '0)
            $display("FAIL rstmid_clear: got %h want 0",
                     {o_in_db, o_rise, o_fall, o_evt_pend, o_irq, o_led});
        else n_pass++;
        rst_v = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            step();
            n_checks++;
            if (o_in_db !== ((n >= 6) ? 4'hB : 4'h0))
                $display("FAIL rstmid_relatch cycle %0d: got %h want %h", n, o_in_db,
                         (n >= 6) ? 4'hB : 4'h0);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        int rises, falls;
        in_v = '0; clr_v = '0; sel_v = '0;
        do_reset();
        repeat (3) step();
        rises = 0; falls = 0;
        in_v[3] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            in_v[3] = 1'b0;
            if (bp_rise[3]) rises++;
            if (bp_fall[3]) falls++;
            n_checks++;
            if ({bp_in_db[3], bp_rise[3], bp_fall[3]} !== {n == 3, n == 4, n == 5})
                $display("FAIL bypass cycle %0d: got db/rise/fall %b want %b", n,
                         {bp_in_db[3], bp_rise[3], bp_fall[3]}, {n == 3, n == 4, n == 5});
            else n_pass++;
            n_checks++;
            if (o_in_db[3] !== 1'b0)
                $display("FAIL bypass_main_reject cycle %0d: got %b want 0", n, o_in_db[3]);
            else n_pass++;
        end
        n_checks++;
        if (rises != 1 || falls != 1)
            $display("FAIL bypass_pulses: got %0d rises %0d falls want 1 and 1", rises, falls);
        else n_pass++;
    endtask

    task automatic test_random();
        in_v = '0; clr_v = '0; en_v = '0; sel_v = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NI; k++) if ($urandom_range(0, 5) == 0) in_v[k] = ~in_v[k];
            clr_v = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
            if ($urandom_range(0, 7) == 0) en_v = NI'($urandom);
            if ($urandom_range(0, 15) == 0) sel_v = NI'($urandom);
            if ($urandom_range(0, 7) == 0) led_v = NL'($urandom);
            if ($urandom_range(0, 19) == 0) duty_v = PB'($urandom);
            rst_v = ($urandom_range(0, 249) == 0);
            step();
            n_checks++;
            if ({o_in_db, o_rise, o_fall, o_evt_pend, o_irq, o_led} !==
                {m_db, m_rise, m_fall, m_pend, m_irq, m_led})
                $display("FAIL rnd_main cycle %0d: got %h want %h", c,
                         {o_in_db, o_rise, o_fall, o_evt_pend, o_irq, o_led},
                         {m_db, m_rise, m_fall, m_pend, m_irq, m_led});
            else n_pass++;
            n_checks++;
            if ({bp_in_db, bp_rise, bp_fall, bp_pend, bp_irq, bp_led} !==
                {m_bp, m_bp_rise, m_bp_fall, m_bp_pend, m_bp_irq, m_led})
                $display("FAIL rnd_bypass cycle %0d: got %h want %h", c,
                         {bp_in_db, bp_rise, bp_fall, bp_pend, bp_irq, bp_led},
                         {m_bp, m_bp_rise, m_bp_fall, m_bp_pend, m_bp_irq, m_led});
            else n_pass++;
        end
        rst_v = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_glitch();
        test_events();
        test_pwm();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
